// File: rtl/hbm_seq_pkg.sv
// hbm_seq_pkg: shared FSM states, descriptor field layout and helpers for the HBM layer sequencer
package hbm_seq_pkg;
    typedef enum logic [3:0] {
        IDLE, LOAD, W_START, W_WAIT, I_START, I_WAIT, O_START, O_WAIT, DONE
    } seq_state_e;
    localparam int WID_LSB = 0;
    localparam int WID_W = 4;
    localparam int IID_LSB = 4;
    localparam int IID_W = 4;
    localparam int OID_LSB = 8;
    localparam int OID_W = 3;
    localparam int SKIPW_BIT = 11;
    localparam int CMD_W = 12;
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/hbm_layer_sequencer_if.sv
// hbm_layer_sequencer_if: descriptor queue handshake and HBM param-id/start/done controls
interface hbm_layer_sequencer_if import hbm_seq_pkg::*; #(parameter int OUTPUT_AXI_CHNL = 8);
    logic                       cmd_vld;
    logic                       cmd_rdy;
    logic [CMD_W-1:0]           cmd_dat;
    logic [WID_W-1:0]           weight_param_id;
    logic [IID_W-1:0]           input_param_id;
    logic [OID_W-1:0]           output_param_id;
    logic                       start_read_weight;
    logic                       start_read_input;
    logic [OUTPUT_AXI_CHNL-1:0] start_write_output;
    logic                       weight_done;
    logic                       input_done;
    logic [OUTPUT_AXI_CHNL-1:0] output_done;
    modport slave (
        input  cmd_vld, cmd_dat, weight_done, input_done, output_done,
        output cmd_rdy, weight_param_id, input_param_id, output_param_id,
               start_read_weight, start_read_input, start_write_output
    );
    modport master (
        output cmd_vld, cmd_dat, weight_done, input_done, output_done,
        input  cmd_rdy, weight_param_id, input_param_id, output_param_id,
               start_read_weight, start_read_input, start_write_output
    );
endinterface

// File: rtl/hbm_seq_cmd_fifo.sv
// hbm_seq_cmd_fifo: synchronous descriptor FIFO; a push is refused whenever full, regardless of a same-cycle pop
module hbm_seq_cmd_fifo import hbm_seq_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = mem[rd_ptr[AW-1:0]];
    // storage write; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
    // pointer update, extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/hbm_layer_sequencer.sv
// hbm_layer_sequencer: per-layer weight/input/output phase scheduler; HBM_SEQ_PERF_EN adds last_layer_cycles
module hbm_layer_sequencer import hbm_seq_pkg::*; #(
    parameter int OUTPUT_AXI_CHNL = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hbm_layer_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 layer_done,
`ifdef HBM_SEQ_PERF_EN
    output logic [CNT_WIDTH-1:0] layers_completed,
    output logic [31:0]          last_layer_cycles
`else
    output logic [CNT_WIDTH-1:0] layers_completed
`endif
);
    seq_state_e state;
    logic [CMD_W-1:0] head;
    logic full, empty, pop, skip;
    logic [OUTPUT_AXI_CHNL-1:0] done_mask;
    assign pop = (state == IDLE || state == DONE) && !empty;
    assign busy = state != IDLE;
    assign bus.cmd_rdy = !full;
    hbm_seq_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(bus.cmd_vld),
        .pop(pop),
        .din(bus.cmd_dat),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    // phase FSM; every output is registered from the transition that enters its state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            skip <= 1'b0;
            done_mask <= '0;
            bus.weight_param_id <= '0;
            bus.input_param_id <= '0;
            bus.output_param_id <= '0;
            bus.start_read_weight <= 1'b0;
            bus.start_read_input <= 1'b0;
            bus.start_write_output <= '0;
            layer_done <= 1'b0;
            layers_completed <= '0;
        end else begin
            bus.start_read_weight <= 1'b0;
            bus.start_read_input <= 1'b0;
            bus.start_write_output <= '0;
            layer_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= empty ? IDLE : LOAD;
                    if (!empty) begin
                        bus.weight_param_id <= head[WID_LSB +: WID_W];
                        bus.input_param_id <= head[IID_LSB +: IID_W];
                        bus.output_param_id <= head[OID_LSB +: OID_W];
                        skip <= head[SKIPW_BIT];
                    end
                end
                LOAD: begin
                    state <= skip ? I_START : W_START;
                    bus.start_read_weight <= !skip;
                    bus.start_read_input <= skip;
                end
                W_START: state <= W_WAIT;
                W_WAIT: if (bus.weight_done) begin
                    state <= I_START;
                    bus.start_read_input <= 1'b1;
                end
                I_START: state <= I_WAIT;
                I_WAIT: if (bus.input_done) begin
                    state <= O_START;
                    bus.start_write_output <= '1;
                end
                O_START: begin
                    state <= O_WAIT;
                    done_mask <= '0;
                end
                O_WAIT: begin
                    done_mask <= done_mask | bus.output_done;
                    if ((done_mask | bus.output_done) == '1) begin
                        state <= DONE;
                        layer_done <= 1'b1;
                        layers_completed <= layers_completed + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef HBM_SEQ_PERF_EN
    logic [31:0] cyc_cnt;
    // per-layer cycle counter, captured when the layer finishes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            last_layer_cycles <= '0;
        end else begin
            if (state == LOAD) cyc_cnt <= 32'd1;
            else if (state != IDLE) cyc_cnt <= sat_inc32(cyc_cnt);
            if (state == DONE) last_layer_cycles <= cyc_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_hbm_layer_sequencer.sv
// tb_hbm_layer_sequencer: scoreboard bench with directed and randomized layers for hbm_layer_sequencer
module tb_hbm_layer_sequencer;
    localparam int CH = 8;
    typedef struct {
        int kind;
        logic [3:0] w;
        logic [3:0] i;
        logic [2:0] o;
        logic [15:0] cnt;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, layer_done;
    logic [15:0] layers_completed;
`ifdef HBM_SEQ_PERF_EN
    logic [31:0] last_layer_cycles;
`endif
    logic w_d = 1'b0, i_d = 1'b0, i_spur = 1'b0;
    logic [CH-1:0] o_d = '0;
    int cyc = 0, epoch = 0, pushed = 0;
    int n_cmp = 0, n_bad = 0;
    int w_lat = 0, i_lat = 0;
    bit w_hold = 1'b0, o_hold = 1'b0, b2b_chk = 1'b0;
    int ev_n[4] = '{0, 0, 0, 0};
    int t_ev[4] = '{-1, -1, -1, -1};
    ev_t exp_q[$];
    logic [CH-1:0] o_dir[$];

    hbm_layer_sequencer_if #(.OUTPUT_AXI_CHNL(CH)) bus();
    assign bus.weight_done = w_d;
    assign bus.input_done = i_d | i_spur;
    assign bus.output_done = o_d;

    hbm_layer_sequencer #(.OUTPUT_AXI_CHNL(CH), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .layer_done(layer_done),
`ifdef HBM_SEQ_PERF_EN
        .layers_completed(layers_completed),
        .last_layer_cycles(last_layer_cycles)
`else
        .layers_completed(layers_completed)
`endif
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got %0d compared required finish", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference model: a descriptor expands into its ordered phase events
    function automatic void model_push(input logic [11:0] dat);
        ev_t e;
        pushed++;
        e.w = dat[3:0];
        e.i = dat[7:4];
        e.o = dat[10:8];
        e.cnt = 16'(pushed);
        if (!dat[11]) begin
            e.kind = 0;
            exp_q.push_back(e);
        end
        e.kind = 1;
        exp_q.push_back(e);
        e.kind = 2;
        exp_q.push_back(e);
        e.kind = 3;
        exp_q.push_back(e);
    endfunction

    task automatic send(input logic [11:0] dat, output int acc);
        int b;
        b = 0;
        acc = -1;
        bus.cmd_vld = 1'b1;
        bus.cmd_dat = dat;
        @(negedge clk);
        while (!bus.cmd_rdy && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (bus.cmd_rdy) begin
            acc = cyc;
            model_push(dat);
        end else check("cmd_accept_timeout", 64'(b), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int kind, input int target, input string name);
        int b;
        b = 0;
        while (ev_n[kind] < target && b < 3000) begin
            @(posedge clk);
            b++;
        end
        check(name, 64'(ev_n[kind] >= target), 1);
        #1;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a start or layer_done
    initial forever begin : mon
        int n, k;
        ev_t e;
        @(negedge clk);
        if (rst_n) begin
            n = int'(bus.start_read_weight) + int'(bus.start_read_input) + int'(|bus.start_write_output) + int'(layer_done);
            k = bus.start_read_weight ? 0 : bus.start_read_input ? 1 : (|bus.start_write_output) ? 2 : 3;
            if (n > 1) check("single_event", 64'(n), 1);
            else if (n == 1) begin
                if (b2b_chk && k == 0) check("b2b_wstart_gap", 64'(cyc - t_ev[3]), 2);
                ev_n[k]++;
                t_ev[k] = cyc;
                if (exp_q.size() == 0) check("unexpected_event", 64'(k), 4);
                else begin
                    e = exp_q.pop_front();
                    check("event_kind", 64'(k), 64'(e.kind));
                    check("param_ids", {bus.weight_param_id, bus.input_param_id, bus.output_param_id}, {e.w, e.i, e.o});
                    check("busy_active", 64'(busy), 1);
                    if (k == 2) check("owrite_all_bits", 64'(bus.start_write_output), 64'({CH{1'b1}}));
                    if (k == 3) check("layers_completed", 64'(layers_completed), 64'(e.cnt));
                end
            end
        end
    end

    // weight read responder
    initial forever begin : wresp
        int d;
        @(negedge clk);
        if (bus.start_read_weight) begin
            d = w_lat > 0 ? w_lat : int'($urandom_range(1, 6));
            repeat (d) @(posedge clk);
            while (w_hold) @(posedge clk);
            #1 w_d = 1'b1;
            @(posedge clk);
            #1 w_d = 1'b0;
        end
    end

    // input read responder
    initial forever begin : iresp
        int d;
        @(negedge clk);
        if (bus.start_read_input) begin
            d = i_lat > 0 ? i_lat : int'($urandom_range(1, 6));
            repeat (d) @(posedge clk);
            #1 i_d = 1'b1;
            @(posedge clk);
            #1 i_d = 1'b0;
        end
    end

    // output write responder: plays a per-cycle channel completion schedule
    initial forever begin : oresp
        logic [CH-1:0] sch[$];
        logic [CH-1:0] m;
        int lat[CH];
        int ep;
        @(negedge clk);
        if (|bus.start_write_output) begin
            ep = epoch;
            sch.delete();
            if (o_dir.size() > 0) sch = o_dir;
            else begin
                for (int c = 0; c < CH; c++) lat[c] = int'($urandom_range(1, 5));
                for (int t = 1; t <= 5; t++) begin
                    m = '0;
                    for (int c = 0; c < CH; c++) m[c] = lat[c] == t;
                    sch.push_back(m);
                end
            end
            while (o_hold) @(posedge clk);
            if (ep == epoch) foreach (sch[j]) begin
                @(posedge clk);
                #1 o_d = sch[j];
            end
            @(posedge clk);
            #1 o_d = '0;
        end
    end

    initial begin
        int acc, acc5, base, prev, snap;
        logic [11:0] d;
        bus.cmd_vld = 1'b0;
        bus.cmd_dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy", 64'(bus.cmd_rdy), 1);
        check("rst_outputs", {bus.weight_param_id, bus.input_param_id, bus.output_param_id, bus.start_read_weight,
              bus.start_read_input, bus.start_write_output, busy, layer_done, layers_completed}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        w_lat = 5;
        i_lat = 4;
        o_dir = '{8'hFF};
        send(12'h0A3, acc);
        bus.cmd_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ids_at_load", {bus.weight_param_id, bus.input_param_id, bus.output_param_id}, {4'd3, 4'd10, 3'd0});
        wait_ev(3, 1, "layer1_done");
        check("latency_wstart", 64'(t_ev[0] - acc), 3);
        check("weight_to_input", 64'(t_ev[1] - t_ev[0]), 6);
        check("input_to_output", 64'(t_ev[2] - t_ev[1]), 5);
        check("output_to_done", 64'(t_ev[3] - t_ev[2]), 2);
        check("count_first", 64'(layers_completed), 1);

        w_lat = 2;
        i_lat = 2;
        o_dir = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h01, 8'h20, 8'h40, 8'h80};
        send(12'h1B5, acc);
        bus.cmd_vld = 1'b0;
        wait_ev(3, 2, "stagger_done");
        check("stagger_done_gap", 64'(t_ev[3] - t_ev[2]), 10);
        o_dir.delete();

        prev = ev_n[0];
        send(12'h812, acc);
        bus.cmd_vld = 1'b0;
        wait_ev(3, 3, "skip_done");
        check("skip_istart_latency", 64'(t_ev[1] - acc), 3);
        check("skip_no_wstart", 64'(ev_n[0]), 64'(prev));

        w_hold = 1'b1;
        i_lat = 4;
        send(12'h0C7, acc);
        bus.cmd_vld = 1'b0;
        wait_ev(0, ev_n[0] + 1, "spur_wstart");
        repeat (2) @(posedge clk);
        #1 i_spur = 1'b1;
        @(posedge clk);
        #1 i_spur = 1'b0;
        w_hold = 1'b0;
        wait_ev(3, 4, "spur_done");
        check("spur_ignored_gap", 64'(t_ev[2] - t_ev[1]), 5);

        w_lat = 0;
        i_lat = 0;
        w_hold = 1'b1;
        base = ev_n[3];
        send(12'h3A1, acc);
        bus.cmd_vld = 1'b0;
        wait_ev(0, ev_n[0] + 1, "full_first_wstart");
        for (int k = 0; k < 4; k++) begin
            d = 12'($urandom) & 12'h7FF;
            send(d, acc);
        end
        d = 12'($urandom) & 12'h7FF;
        bus.cmd_dat = d;
        @(negedge clk);
        check("full_rdy_low", 64'(bus.cmd_rdy), 0);
        b2b_chk = 1'b1;
        fork
            send(d, acc5);
            begin
                repeat (3) @(posedge clk);
                #1 w_hold = 1'b0;
            end
        join
        bus.cmd_vld = 1'b0;
        check("fifth_accept_after_pop", 64'(acc5 - t_ev[3]), 1);
        wait_ev(3, base + 6, "full_all_done");
        b2b_chk = 1'b0;

        o_hold = 1'b1;
        send(12'h2C4, acc);
        bus.cmd_vld = 1'b0;
        wait_ev(2, ev_n[2] + 1, "rst_owait_reached");
        send(12'h155, acc);
        send(12'h9AA, acc);
        bus.cmd_vld = 1'b0;
        rst_n = 1'b0;
        epoch++;
        exp_q.delete();
        pushed = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cmd_rdy", 64'(bus.cmd_rdy), 1);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_outputs", {bus.weight_param_id, bus.input_param_id, bus.output_param_id, bus.start_read_weight,
              bus.start_read_input, bus.start_write_output, layer_done, layers_completed}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        o_hold = 1'b0;
        snap = ev_n[0] + ev_n[1] + ev_n[2] + ev_n[3];
        repeat (20) @(posedge clk);
        check("no_event_after_reset", 64'(ev_n[0] + ev_n[1] + ev_n[2] + ev_n[3] - snap), 0);

        base = ev_n[3];
        #1;
        for (int k = 0; k < 20; k++) begin
            d = 12'($urandom);
            prev = int'($urandom_range(0, 3));
            if (prev > 0) begin
                bus.cmd_vld = 1'b0;
                repeat (prev) @(posedge clk);
                #1;
            end
            send(d, acc);
        end
        bus.cmd_vld = 1'b0;
        wait_ev(3, base + 20, "random_all_done");
        check("random_final_count", 64'(layers_completed), 64'(pushed));
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hbm_layer_sequencer.md
Name: hbm_layer_sequencer

Overview:
- Per-layer command scheduler in front of the HBM subsystem.
- Accepts layer descriptors through a valid/ready queue and drives the HBM subsystem's param-id and start controls.
- For each descriptor, sequences three phases in order: weight read, input read, output write. Each phase waits for its done indication before the next phase starts.
- Sits between the host/top-level control and the HBM wrapper, on the ddr_clk domain.

Parameters:
- OUTPUT_AXI_CHNL, 8, number of output write channels; width of the start/done masks.
- FIFO_DEPTH, 4, descriptor queue depth; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the completed-layer counter.

Ports:
- clk  in  1  ddr clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_vld  in  1  descriptor valid.
- cmd_rdy  out  1  descriptor queue not full.
- cmd_dat  in  12  descriptor fields: [3:0] weight_param_id, [7:4] input_param_id, [10:8] output_param_id, [11] skip_weight.
- weight_param_id  out  4  weight param-id selection for the HBM subsystem.
- input_param_id  out  4  input param-id selection for the HBM subsystem.
- output_param_id  out  3  output param-id selection for the HBM subsystem.
- start_read_weight  out  1  one-cycle start pulse for the weight read.
- start_read_input  out  1  one-cycle start pulse for the input read.
- start_write_output  out  OUTPUT_AXI_CHNL  one-cycle start pulse, all bits asserted together.
- weight_done  in  1  weight read complete, single-cycle pulse.
- input_done  in  1  input read complete, single-cycle pulse.
- output_done  in  OUTPUT_AXI_CHNL  per-channel write complete pulses; channels may complete in different cycles.
- busy  out  1  high whenever the FSM is not in IDLE.
- layer_done  out  1  one-cycle pulse when a layer finishes.
- layers_completed  out  CNT_WIDTH  count of finished layers; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset: every output is 0 except cmd_rdy, which is 1. The FIFO is emptied, the FSM goes to IDLE and the done mask is cleared. Reset asserted mid-operation aborts the layer immediately; no layer_done is produced.
- Queue:
  - Push when cmd_vld & cmd_rdy.
  - cmd_rdy = !full. A push is refused when the queue is full, even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, W_START, W_WAIT, I_START, I_WAIT, O_START, O_WAIT, DONE.
  - IDLE: if the FIFO is not empty, pop it, register the descriptor and go to LOAD. Otherwise stay.
  - LOAD: the param-id outputs carry the new ids. This gives the HBM control registers a settle cycle. Next state is I_START if skip_weight, else W_START.
  - W_START: start_read_weight=1 for this cycle only, then W_WAIT.
  - W_WAIT: go to I_START the cycle after weight_done is seen high.
  - I_START: start_read_input=1 for this cycle, then I_WAIT.
  - I_WAIT: go to O_START the cycle after input_done is seen high.
  - O_START: start_write_output is all ones for this cycle, the done mask is cleared, then O_WAIT.
  - O_WAIT: done mask |= output_done every cycle. When (mask | output_done) is all ones, go to DONE.
  - DONE: layer_done=1 for this cycle and layers_completed increments. Go to LOAD directly if the FIFO is not empty (popping in this cycle), else IDLE.
- Param-id outputs are registered. They hold from LOAD through DONE and keep their last values while in IDLE.
- Done inputs are ignored outside their WAIT state; no sticky capture, except the output mask in O_WAIT.
- A done pulse in the same cycle as the corresponding START is ignored.
- Latency: a descriptor accepted in cycle 0 with the sequencer idle and the queue empty gives LOAD in cycle 2 and start_read_weight in cycle 3.
- Back-to-back layers: DONE to LOAD with no IDLE cycle.

Optional Feature:
- Macro: HBM_SEQ_PERF_EN.
- When defined, adds an output last_layer_cycles [31:0].
  - An internal counter loads 1 in LOAD and increments each cycle through DONE, saturating at 0xFFFFFFFF.
  - Its value is copied to last_layer_cycles on DONE; the output resets to 0.
- When undefined: no port and no counter logic.

Decomposition:
- Package hbm_seq_pkg holds:
  - the FSM state enum;
  - descriptor field offsets and widths (WID_LSB=0, IID_LSB=4, OID_LSB=8, SKIPW_BIT=11, CMD_W=12).
- Sub-module hbm_seq_cmd_fifo: synchronous FIFO, CMD_W wide, FIFO_DEPTH deep, with push/pop/full/empty.

Test Plan:
- Single layer, cmd_dat=0x0A3 (wid=3, iid=10, oid=0, skip=0): weight_done 5 cycles after W_START, input_done 4 cycles after I_START, all output_done together -> pulse order weight, input, output. Ids read 3/10/0 from LOAD on. layer_done once; layers_completed=1.
- Staggered output completion, OUTPUT_AXI_CHNL=8: output_done bits 0..7 one per cycle -> DONE only in the cycle after bit 7; a repeated bit 0 changes nothing.
- skip_weight=1 (cmd_dat=0x812) -> start_read_weight never pulses; start_read_input is high in the cycle after LOAD.
- Queue full: push 5 descriptors back-to-back while the FSM is stuck in W_WAIT -> cmd_rdy low after 4 accepted. The 5th is held off and accepted after the first pop. All 5 layers complete in order with back-to-back DONE to LOAD.
- Spurious done: pulse input_done during W_WAIT -> ignored; the FSM still waits in I_WAIT for a new input_done.
- Reset in O_WAIT with 2 queued descriptors -> next cycle all outputs 0, cmd_rdy=1, busy=0. The queue is empty and no start pulse follows.
